// File: rtl/reg_mem_fifo_if.sv
// Producer/consumer stream bundle for reg_mem_fifo; slave is the FIFO side.
interface reg_mem_fifo_if #(
   parameter int WIDTH = 16
);
   logic             inValid_i;
   logic             inReady_o;
   logic [WIDTH-1:0] inData_i;
   logic             outValid_o;
   logic             outReady_i;
   logic [WIDTH-1:0] outData_o;

   modport slave (
      input  inValid_i, inData_i, outReady_i,
      output inReady_o, outValid_o, outData_o
   );

   modport master (
      output inValid_i, inData_i, outReady_i,
      input  inReady_o, outValid_o, outData_o
   );
endinterface

// File: rtl/reg_mem_fifo.sv
// FIFO controller over an external two-port registered memory; push-to-output 2 cycles, 1 word/cycle.
// Backpressure: inReady_o drops when the memory is full; output register holds while outReady_i is low.
module reg_mem_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   reg_mem_fifo_if.slave              bus,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       memReadEnable_o,
   output logic [$clog2(DEPTH)-1:0]   memReadAddr_o,
   input  logic [WIDTH-1:0]           memReadData_i,
   output logic                       memWriteEnable_o,
   output logic [$clog2(DEPTH)-1:0]   memWriteAddr_o,
   output logic [WIDTH-1:0]           memWriteData_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = DEPTH[AW:0];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   mem_count_q, mem_count_d;
   logic [AW:0]   level_q, level_d;
   logic          out_valid_q, out_valid_d;
   logic          in_ready;
   logic          push;
   logic          read;

   assign in_ready = (mem_count_q != FULL);

   // Strobes are gated with rst_ni so the memory sees no access while reset is held.
   assign push = bus.inValid_i && in_ready && !flush_i && rst_ni;
   assign read = (mem_count_q != '0) && (!out_valid_q || bus.outReady_i) && !flush_i && rst_ni;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      mem_count_d = mem_count_q;
      out_valid_d = out_valid_q;
      level_d     = level_q;

      if (flush_i) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         mem_count_d = '0;
         out_valid_d = 1'b0;
         level_d     = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (read) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         if (push && !read) begin
            mem_count_d = mem_count_q + (AW+1)'(1);
         end else if (read && !push) begin
            mem_count_d = mem_count_q - (AW+1)'(1);
         end
         if (read) begin
            out_valid_d = 1'b1;
         end else if (bus.outReady_i) begin
            out_valid_d = 1'b0;
         end
         level_d = mem_count_d + {{AW{1'b0}}, out_valid_d};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_count_q <= '0;
         out_valid_q <= 1'b0;
         level_q     <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_count_q <= mem_count_d;
         out_valid_q <= out_valid_d;
         level_q     <= level_d;
      end
   end

   // The memory's read register is the output stage; no local data copy.
   assign bus.inReady_o    = in_ready;
   assign bus.outValid_o   = out_valid_q;
   assign bus.outData_o    = memReadData_i;
   assign level_o          = level_q;
   assign memReadEnable_o  = read;
   assign memReadAddr_o    = rd_ptr_q;
   assign memWriteEnable_o = push;
   assign memWriteAddr_o   = wr_ptr_q;
   assign memWriteData_o   = bus.inData_i;
endmodule

// File: tb/tb_reg_mem_fifo.sv
// Directed bench for reg_mem_fifo (DEPTH=4) with a two-port registered memory attached.
module tb_reg_mem_fifo;
   localparam int WIDTH = 16;
   localparam int DEPTH = 4;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              flush_i;
   logic [2:0]        level_o;
   logic              memReadEnable_o;
   logic [1:0]        memReadAddr_o;
   logic [WIDTH-1:0]  memReadData_i;
   logic              memWriteEnable_o;
   logic [1:0]        memWriteAddr_o;
   logic [WIDTH-1:0]  memWriteData_o;

   reg_mem_fifo_if #(.WIDTH(WIDTH)) bus ();

   reg_mem_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .flush_i          (flush_i),
      .bus              (bus),
      .level_o          (level_o),
      .memReadEnable_o  (memReadEnable_o),
      .memReadAddr_o    (memReadAddr_o),
      .memReadData_i    (memReadData_i),
      .memWriteEnable_o (memWriteEnable_o),
      .memWriteAddr_o   (memWriteAddr_o),
      .memWriteData_o   (memWriteData_o)
   );

   always #5 clk_i = ~clk_i;

   logic [WIDTH-1:0] mem [DEPTH];
   always @(posedge clk_i) begin
      if (memWriteEnable_o) mem[memWriteAddr_o] <= memWriteData_o;
      if (memReadEnable_o)  memReadData_i <= mem[memReadAddr_o];
   end

   typedef struct {
      logic        flush;
      logic        in_vld;
      logic [15:0] in_dat;
      logic        out_rdy;
      logic        e_in_rdy;
      logic        e_out_vld;
      logic [15:0] e_dat;
      logic [2:0]  e_lvl;
      logic        e_re;
      logic        e_we;
   } vec_t;

   int n_pass = 0;
   int n_total = 0;
   vec_t tbl[$];

   function automatic vec_t mk(logic fl, logic iv, logic [15:0] id, logic ordy,
                               logic eir, logic eov, logic [15:0] ed, logic [2:0] el,
                               logic ere, logic ewe);
      vec_t v;
      v.flush = fl; v.in_vld = iv; v.in_dat = id; v.out_rdy = ordy;
      v.e_in_rdy = eir; v.e_out_vld = eov; v.e_dat = ed; v.e_lvl = el;
      v.e_re = ere; v.e_we = ewe;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic drive(input logic fl, input logic iv, input logic [15:0] id, input logic ordy);
      flush_i        = fl;
      bus.inValid_i  = iv;
      bus.inData_i   = id;
      bus.outReady_i = ordy;
   endtask

   // Entered just after a rising edge; checks at the falling edge, then advances one cycle.
   task automatic step(input string tag, input vec_t v);
      drive(v.flush, v.in_vld, v.in_dat, v.out_rdy);
      @(negedge clk_i);
      chk({tag, " in_rdy"},  32'(bus.inReady_o),    32'(v.e_in_rdy));
      chk({tag, " out_vld"}, 32'(bus.outValid_o),   32'(v.e_out_vld));
      chk({tag, " level"},   32'(level_o),          32'(v.e_lvl));
      chk({tag, " rd_en"},   32'(memReadEnable_o),  32'(v.e_re));
      chk({tag, " wr_en"},   32'(memWriteEnable_o), 32'(v.e_we));
      if (v.e_out_vld) chk({tag, " data"}, 32'(bus.outData_o), 32'(v.e_dat));
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      // single word, fill to DEPTH+1, drain in order
      tbl.push_back(mk(0,1,16'h1234,0, 1,0,16'h0,   0,0,1));
      tbl.push_back(mk(0,0,16'h0,   0, 1,0,16'h0,   1,1,0));
      tbl.push_back(mk(0,0,16'h0,   0, 1,1,16'h1234,1,0,0));
      tbl.push_back(mk(0,0,16'h0,   1, 1,1,16'h1234,1,0,0));
      tbl.push_back(mk(0,0,16'h0,   0, 1,0,16'h0,   0,0,0));
      tbl.push_back(mk(0,1,16'hA0,  0, 1,0,16'h0,   0,0,1));
      tbl.push_back(mk(0,1,16'hA1,  0, 1,0,16'h0,   1,1,1));
      tbl.push_back(mk(0,1,16'hA2,  0, 1,1,16'hA0,  2,0,1));
      tbl.push_back(mk(0,1,16'hA3,  0, 1,1,16'hA0,  3,0,1));
      tbl.push_back(mk(0,1,16'hA4,  0, 1,1,16'hA0,  4,0,1));
      tbl.push_back(mk(0,1,16'hA5,  0, 0,1,16'hA0,  5,0,0));
      tbl.push_back(mk(0,0,16'h0,   1, 0,1,16'hA0,  5,1,0));
      tbl.push_back(mk(0,0,16'h0,   1, 1,1,16'hA1,  4,1,0));
      tbl.push_back(mk(0,0,16'h0,   1, 1,1,16'hA2,  3,1,0));
      tbl.push_back(mk(0,0,16'h0,   1, 1,1,16'hA3,  2,1,0));
      tbl.push_back(mk(0,0,16'h0,   1, 1,1,16'hA4,  1,0,0));
      tbl.push_back(mk(0,0,16'h0,   0, 1,0,16'h0,   0,0,0));
      // backpressure hold with a second word queued behind 0x55
      tbl.push_back(mk(0,1,16'h55,  0, 1,0,16'h0,   0,0,1));
      tbl.push_back(mk(0,1,16'h66,  0, 1,0,16'h0,   1,1,1));
      tbl.push_back(mk(0,0,16'h0,   0, 1,1,16'h55,  2,0,0));
      tbl.push_back(mk(0,0,16'h0,   0, 1,1,16'h55,  2,0,0));
      tbl.push_back(mk(0,0,16'h0,   0, 1,1,16'h55,  2,0,0));
      tbl.push_back(mk(0,0,16'h0,   1, 1,1,16'h55,  2,1,0));
      tbl.push_back(mk(0,0,16'h0,   1, 1,1,16'h66,  1,0,0));
      tbl.push_back(mk(0,0,16'h0,   0, 1,0,16'h0,   0,0,0));

      rst_ni = 1'b0;
      drive(0, 0, 16'h0, 0);
      #2;
      chk("reset out_vld", 32'(bus.outValid_o),   32'd0);
      chk("reset level",   32'(level_o),          32'd0);
      chk("reset in_rdy",  32'(bus.inReady_o),    32'd1);
      chk("reset rd_en",   32'(memReadEnable_o),  32'd0);
      chk("reset wr_en",   32'(memWriteEnable_o), 32'd0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;

      for (int i = 0; i < tbl.size(); i++) step($sformatf("vec%0d", i), tbl[i]);

      // streaming: 20 words, pointers wrap several times, steady level 2
      for (int c = 0; c < 22; c++) begin
         drive(0, c < 20, 16'(16'h100 + c), 1);
         @(negedge clk_i);
         chk($sformatf("stream%0d in_rdy", c), 32'(bus.inReady_o), 32'd1);
         chk($sformatf("stream%0d level", c), 32'(level_o),
             (c == 0) ? 32'd0 : (c == 1 || c == 21) ? 32'd1 : 32'd2);
         chk($sformatf("stream%0d out_vld", c), 32'(bus.outValid_o), (c >= 2) ? 32'd1 : 32'd0);
         if (c >= 2) chk($sformatf("stream%0d data", c), 32'(bus.outData_o), 32'(16'h100 + c - 2));
         @(posedge clk_i);
         #1;
      end
      step("stream_end", mk(0,0,16'h0,0, 1,0,16'h0,0,0,0));

      // flush with push and pop requested in the same cycle
      step("fl0", mk(0,1,16'hC1,0, 1,0,16'h0, 0,0,1));
      step("fl1", mk(0,1,16'hC2,0, 1,0,16'h0, 1,1,1));
      step("fl2", mk(0,1,16'hC3,0, 1,1,16'hC1,2,0,1));
      step("fl3", mk(1,1,16'hC4,1, 1,1,16'hC1,3,0,0));
      step("fl4", mk(0,0,16'h0, 0, 1,0,16'h0, 0,0,0));
      step("fl5", mk(0,1,16'h77,0, 1,0,16'h0, 0,0,1));
      step("fl6", mk(0,0,16'h0, 0, 1,0,16'h0, 1,1,0));
      step("fl7", mk(0,0,16'h0, 1, 1,1,16'h77,1,0,0));
      step("fl8", mk(0,0,16'h0, 0, 1,0,16'h0, 0,0,0));

      // asynchronous reset between edges while streaming
      step("ar0", mk(0,1,16'h200,1, 1,0,16'h0,  0,0,1));
      step("ar1", mk(0,1,16'h201,1, 1,0,16'h0,  1,1,1));
      step("ar2", mk(0,1,16'h202,1, 1,1,16'h200,2,1,1));
      drive(0, 1, 16'h203, 1);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst out_vld", 32'(bus.outValid_o),   32'd0);
      chk("arst level",   32'(level_o),          32'd0);
      chk("arst in_rdy",  32'(bus.inReady_o),    32'd1);
      chk("arst rd_en",   32'(memReadEnable_o),  32'd0);
      chk("arst wr_en",   32'(memWriteEnable_o), 32'd0);
      @(posedge clk_i);
      #1;
      chk("arst held level", 32'(level_o), 32'd0);
      rst_ni = 1'b1;
      step("ar3", mk(0,1,16'hBEEF,0, 1,0,16'h0,   0,0,1));
      step("ar4", mk(0,0,16'h0,   0, 1,0,16'h0,   1,1,0));
      step("ar5", mk(0,0,16'h0,   1, 1,1,16'hBEEF,1,0,0));
      step("ar6", mk(0,0,16'h0,   0, 1,0,16'h0,   0,0,0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
